sh7604_ibus_initiator: RTL and testbench
========================================

Name: sh7604_ibus_initiator

Overview:
CPU-side initiator for the SH7604 internal peripheral bus (IBUS). It accepts one CPU byte, word or long access at a time and drives the IBUS request lines that on-chip peripherals (FRT, SCI, WDT and others) respond to. Word and long accesses into the 8-bit peripheral region are split into sequential byte transactions, lowest address first. This ordering makes peripheral high-byte TEMP latching work. It also handles peripheral wait states, open-bus reads, misalignment and a wait-state timeout.

Parameters:
BYTE_LO, 32'hFFFFFE00, first address of the 8-bit-only peripheral region
BYTE_HI, 32'hFFFFFE7F, last address of the 8-bit-only peripheral region
TIMEOUT, 256, maximum consecutive CE_R ticks with IBUS_BUSY=1 before abort (8..1024)

Ports:
CLK  in  1  system clock; the only clock
RST_N  in  1  asynchronous active-low reset
CE_R  in  1  rising-phase clock enable; all state advances only on CE_R
CE_F  in  1  falling-phase enable (unused internally; present for port uniformity)
EN  in  1  stall; when 0 all state and outputs hold
CPU_A  in  32  access address
CPU_DI  in  32  write data, big-endian lane-aligned (addr[1:0]=0 on [31:24])
CPU_SZ  in  2  0=byte, 1=word, 2=long, 3=reserved (treated as long)
CPU_WE  in  1  1=write
CPU_REQ  in  1  access request; held until CPU_BUSY=0
CPU_DO  out  32  read data, lane-aligned; valid when CPU_BUSY falls
CPU_BUSY  out  1  access in progress
ADDR_ERR  out  1  one-CE_R pulse: misaligned access rejected
BUS_ERR  out  1  one-CE_R pulse: timeout abort
IBUS_A  out  32  peripheral address
IBUS_DO  out  32  write data to peripheral
IBUS_DI  in  32  read data from peripheral (combinational while selected)
IBUS_BA  out  4  byte-lane enables; [3]=lane 0 ([31:24])
IBUS_WE  out  1  write strobe
IBUS_REQ  out  1  transaction request
IBUS_BUSY  in  1  peripheral wait
IBUS_ACT  in  1  a peripheral decodes IBUS_A

Behaviour:
- Reset (async, RST_N=0): state IDLE. IBUS_REQ, IBUS_WE, IBUS_BA, IBUS_A, IBUS_DO, CPU_DO, ADDR_ERR and BUS_ERR are all 0. The timeout counter is 0. Reset mid-access abandons the access without completing any further phase.
- The state machine has four states: IDLE, PHASE, DONE and ERR. Transitions occur only on CLK edges with CE_R=1 and EN=1.
- IDLE:
  - When CPU_REQ=1, latch A, DI, SZ and WE.
  - Misaligned accesses go to ERR with no IBUS activity. Misaligned means word with A[0]=1, or long with A[1:0]≠0.
  - In the byte region (BYTE_LO ≤ A ≤ BYTE_HI), the phase count is 1 for byte, 2 for word, 4 for long. Outside it, a single full-size phase is used.
  - Go to PHASE with IBUS_REQ=1, driving the first phase.
- PHASE drive values:
  - IBUS_A = base address + phase index.
  - IBUS_BA is a one-hot lane for byte phases. Full-size phases use 1100 or 0011 for a word and 1111 for a long.
  - IBUS_DO = latched DI; the lanes are already aligned.
  - IBUS_WE = latched WE.
- PHASE completion (each CE_R tick):
  - If IBUS_BUSY=1, hold all outputs and increment the timeout counter. When the counter reaches TIMEOUT, go to ERR.
  - If IBUS_BUSY=0, the phase completes. On a read, merge the IBUS_DI enabled lanes into CPU_DO. If IBUS_ACT=0, merge 0 instead (open bus).
  - After completion, clear the timeout counter. Then either advance to the next phase (IBUS_REQ stays 1) or go to DONE with IBUS_REQ=0 and IBUS_BA=0.
- Minimum latency is one CE_R tick per phase. Peripherals load read data on CE_F while IBUS_REQ=1, so it is valid at the next CE_R.
- CPU_BUSY = CPU_REQ & (state≠DONE) & (state≠ERR), combinational.
- DONE and ERR last one CE_R tick and then return to IDLE.
  - ERR pulses ADDR_ERR or BUS_ERR accordingly and sets CPU_DO=0.
  - A new CPU_REQ is accepted only from IDLE. Back-to-back accesses therefore have a one-tick gap.
- Counter width: 11 bits. It saturates at TIMEOUT and never wraps.
- EN=0 in any state: no transition, counter frozen, IBUS outputs held.
- CPU_REQ dropping mid-access is ignored; the access runs to completion.

Test Plan:
- Word write 0x1234 to 0xFFFFFE12, no wait.
  - Phase 1: A=FE12, BA=0010, DO[15:8]=12, WE=1.
  - Phase 2: A=FE13, BA=0001, DO[7:0]=34.
  - CPU_BUSY falls after 3 CE_R ticks.
- Long read at 0xFFFFFE10 with bytes AA, BB, CC, DD returned per phase: 4 phases at FE10–FE13, then CPU_DO=AABBCCDD.
- Long read at 0xFFFFFF00 (outside the byte region): a single phase with BA=1111 and CPU_DO=IBUS_DI.
- IBUS_BUSY=1 for 5 ticks on phase 1 of a word read: outputs stable throughout, completion delayed 5 ticks, no BUS_ERR.
- IBUS_BUSY stuck at 1 with TIMEOUT=8: BUS_ERR pulses after 8 ticks, IBUS_REQ returns to 0, CPU_DO=0.
- Misaligned and disruption cases:
  - Word at 0xFFFFFE11: ADDR_ERR pulse and IBUS_REQ never asserted.
  - RST_N low during phase 2: outputs 0 immediately.
  - EN=0 for 3 ticks mid-phase: full freeze.

Source files
------------

// File: rtl/sh7604_ibus_initiator.sv
// SH7604 IBUS initiator: turns one CPU access into one or more IBUS phases,
// serialising the 8-bit peripheral region byte by byte, lowest address first.
module sh7604_ibus_initiator #(
   parameter logic [31:0] BYTE_LO = 32'hFFFFFE00,
   parameter logic [31:0] BYTE_HI = 32'hFFFFFE7F,
   parameter int          TIMEOUT = 256
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        CE_R,
   input  logic        CE_F,
   input  logic        EN,
   input  logic [31:0] CPU_A,
   input  logic [31:0] CPU_DI,
   input  logic [1:0]  CPU_SZ,
   input  logic        CPU_WE,
   input  logic        CPU_REQ,
   output logic [31:0] CPU_DO,
   output logic        CPU_BUSY,
   output logic        ADDR_ERR,
   output logic        BUS_ERR,
   output logic [31:0] IBUS_A,
   output logic [31:0] IBUS_DO,
   input  logic [31:0] IBUS_DI,
   output logic [3:0]  IBUS_BA,
   output logic        IBUS_WE,
   output logic        IBUS_REQ,
   input  logic        IBUS_BUSY,
   input  logic        IBUS_ACT
);
   typedef enum logic [1:0] {IDLE, PHASE, DONE, ERR} state_t;

   localparam logic [10:0] TIMEOUT_C = 11'(TIMEOUT);

   state_t      state, state_next;
   logic [31:0] base, base_next;
   logic [1:0]  sz, sz_next;
   logic        byte_mode, byte_mode_next;
   logic [1:0]  idx, idx_next;
   logic [1:0]  last, last_next;
   logic [10:0] cnt, cnt_next;
   logic [31:0] cpu_do, cpu_do_next;
   logic        addr_err, addr_err_next;
   logic        bus_err, bus_err_next;
   logic [31:0] ibus_a, ibus_a_next;
   logic [31:0] ibus_do, ibus_do_next;
   logic [3:0]  ibus_ba, ibus_ba_next;
   logic        ibus_we, ibus_we_next;
   logic        ibus_req, ibus_req_next;

   logic        in_region, misaligned;
   logic [10:0] cnt_inc;
   logic [31:0] rd_mask, next_addr;
   logic        unused_ce_f;

   assign unused_ce_f = CE_F;

   // Byte phases (and plain byte accesses) use a single lane; wider phases cover the whole datum.
   function automatic logic [3:0] lane_mask(input logic [1:0] a_lo, input logic single,
                                            input logic [1:0] size);
      if (single || size == 2'd0)
         lane_mask = 4'b1000 >> a_lo;
      else if (size == 2'd1)
         lane_mask = a_lo[1] ? 4'b0011 : 4'b1100;
      else
         lane_mask = 4'b1111;
   endfunction

   function automatic logic [31:0] lanes32(input logic [3:0] m);
      lanes32 = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
   endfunction

   always_comb begin
      state_next     = state;
      base_next      = base;
      sz_next        = sz;
      byte_mode_next = byte_mode;
      idx_next       = idx;
      last_next      = last;
      cnt_next       = cnt;
      cpu_do_next    = cpu_do;
      addr_err_next  = addr_err;
      bus_err_next   = bus_err;
      ibus_a_next    = ibus_a;
      ibus_do_next   = ibus_do;
      ibus_ba_next   = ibus_ba;
      ibus_we_next   = ibus_we;
      ibus_req_next  = ibus_req;

      in_region  = (CPU_A >= BYTE_LO) && (CPU_A <= BYTE_HI);
      misaligned = (CPU_SZ == 2'd1 && CPU_A[0]) || (CPU_SZ[1] && CPU_A[1:0] != 2'd0);
      cnt_inc    = cnt + 11'd1;
      rd_mask    = lanes32(ibus_ba);
      next_addr  = base + {30'd0, idx + 2'd1};

      if (CE_R && EN) begin
         unique case (state)
            IDLE: begin
               addr_err_next = 1'b0;
               bus_err_next  = 1'b0;
               if (CPU_REQ) begin
                  base_next      = CPU_A;
                  sz_next        = CPU_SZ;
                  byte_mode_next = in_region;
                  cpu_do_next    = '0;
                  cnt_next       = '0;
                  idx_next       = '0;
                  if (misaligned) begin
                     state_next    = ERR;
                     addr_err_next = 1'b1;
                  end else begin
                     last_next     = !in_region ? 2'd0 :
                                     (CPU_SZ == 2'd0) ? 2'd0 :
                                     (CPU_SZ == 2'd1) ? 2'd1 : 2'd3;
                     ibus_a_next   = CPU_A;
                     ibus_ba_next  = lane_mask(CPU_A[1:0], in_region, CPU_SZ);
                     ibus_do_next  = CPU_DI;
                     ibus_we_next  = CPU_WE;
                     ibus_req_next = 1'b1;
                     state_next    = PHASE;
                  end
               end
            end
            PHASE: begin
               if (IBUS_BUSY) begin
                  cnt_next = cnt_inc;
                  if (cnt_inc >= TIMEOUT_C) begin
                     state_next    = ERR;
                     bus_err_next  = 1'b1;
                     cpu_do_next   = '0;
                     ibus_req_next = 1'b0;
                     ibus_ba_next  = '0;
                     ibus_we_next  = 1'b0;
                  end
               end else begin
                  cnt_next = '0;
                  // An undecoded address reads as zero rather than whatever floats on IBUS_DI.
                  if (!ibus_we)
                     cpu_do_next = (cpu_do & ~rd_mask) | (IBUS_ACT ? (IBUS_DI & rd_mask) : 32'd0);
                  if (idx == last) begin
                     state_next    = DONE;
                     ibus_req_next = 1'b0;
                     ibus_ba_next  = '0;
                     ibus_we_next  = 1'b0;
                  end else begin
                     idx_next     = idx + 2'd1;
                     ibus_a_next  = next_addr;
                     ibus_ba_next = lane_mask(next_addr[1:0], byte_mode, sz);
                  end
               end
            end
            DONE: state_next = IDLE;
            ERR: begin
               addr_err_next = 1'b0;
               bus_err_next  = 1'b0;
               state_next    = IDLE;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state     <= IDLE;
         base      <= '0;
         sz        <= '0;
         byte_mode <= 1'b0;
         idx       <= '0;
         last      <= '0;
         cnt       <= '0;
         cpu_do    <= '0;
         addr_err  <= 1'b0;
         bus_err   <= 1'b0;
         ibus_a    <= '0;
         ibus_do   <= '0;
         ibus_ba   <= '0;
         ibus_we   <= 1'b0;
         ibus_req  <= 1'b0;
      end else begin
         state     <= state_next;
         base      <= base_next;
         sz        <= sz_next;
         byte_mode <= byte_mode_next;
         idx       <= idx_next;
         last      <= last_next;
         cnt       <= cnt_next;
         cpu_do    <= cpu_do_next;
         addr_err  <= addr_err_next;
         bus_err   <= bus_err_next;
         ibus_a    <= ibus_a_next;
         ibus_do   <= ibus_do_next;
         ibus_ba   <= ibus_ba_next;
         ibus_we   <= ibus_we_next;
         ibus_req  <= ibus_req_next;
      end
   end

   assign CPU_DO   = cpu_do;
   assign CPU_BUSY = CPU_REQ && (state != DONE) && (state != ERR);
   assign ADDR_ERR = addr_err;
   assign BUS_ERR  = bus_err;
   assign IBUS_A   = ibus_a;
   assign IBUS_DO  = ibus_do;
   assign IBUS_BA  = ibus_ba;
   assign IBUS_WE  = ibus_we;
   assign IBUS_REQ = ibus_req;
endmodule

// File: tb/tb_sh7604_ibus_initiator.sv
// Scoreboard bench for sh7604_ibus_initiator: a byte-memory peripheral with programmable
// wait states, an access-level reference model, and independent phase/completion monitors.
module tb_sh7604_ibus_initiator;
   localparam int          TMO = 8;
   localparam logic [31:0] LO  = 32'hFFFFFE00;
   localparam logic [31:0] HI  = 32'hFFFFFE7F;

   logic        CLK = 1'b0, RST_N = 1'b0, CE_R = 1'b1, CE_F = 1'b0, EN = 1'b1;
   logic [31:0] CPU_A = '0, CPU_DI = '0;
   logic [1:0]  CPU_SZ = '0;
   logic        CPU_WE = 1'b0, CPU_REQ = 1'b0;
   logic [31:0] CPU_DO, IBUS_A, IBUS_DO, IBUS_DI;
   logic        CPU_BUSY, ADDR_ERR, BUS_ERR, IBUS_WE, IBUS_REQ, IBUS_BUSY, IBUS_ACT;
   logic [3:0]  IBUS_BA;

   int total = 0, bad = 0;
   bit mon_on = 1'b1;

   sh7604_ibus_initiator #(.BYTE_LO(LO), .BYTE_HI(HI), .TIMEOUT(TMO)) dut (
      .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .CE_F(CE_F), .EN(EN),
      .CPU_A(CPU_A), .CPU_DI(CPU_DI), .CPU_SZ(CPU_SZ), .CPU_WE(CPU_WE), .CPU_REQ(CPU_REQ),
      .CPU_DO(CPU_DO), .CPU_BUSY(CPU_BUSY), .ADDR_ERR(ADDR_ERR), .BUS_ERR(BUS_ERR),
      .IBUS_A(IBUS_A), .IBUS_DO(IBUS_DO), .IBUS_DI(IBUS_DI), .IBUS_BA(IBUS_BA),
      .IBUS_WE(IBUS_WE), .IBUS_REQ(IBUS_REQ), .IBUS_BUSY(IBUS_BUSY), .IBUS_ACT(IBUS_ACT));

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      total++;
      bad++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   // Peripheral: addresses with A[6:4]=7 are not decoded (open bus).
   function automatic bit act_of(input logic [31:0] x);
      return x[6:4] != 3'b111;
   endfunction

   logic [7:0] pmem [0:511];
   int wait_cfg = 0;
   int wcnt = 0;

   always @(posedge CLK) begin
      if (!RST_N) begin
         for (int i = 0; i < 512; i++) pmem[i] <= 8'(i * 7 + 3);
         wcnt <= 0;
      end else if (CE_R && EN) begin
         if (IBUS_REQ && IBUS_BUSY) wcnt <= wcnt + 1;
         else wcnt <= 0;
         if (IBUS_REQ && !IBUS_BUSY && IBUS_WE)
            for (int l = 0; l < 4; l++)
               if (IBUS_BA[3-l]) pmem[{IBUS_A[8:2], 2'(l)}] <= IBUS_DO[31-8*l -: 8];
      end
   end

   assign IBUS_BUSY = IBUS_REQ && (wcnt < wait_cfg);
   assign IBUS_ACT  = act_of(IBUS_A);
   assign IBUS_DI   = {pmem[{IBUS_A[8:2], 2'd0}], pmem[{IBUS_A[8:2], 2'd1}],
                       pmem[{IBUS_A[8:2], 2'd2}], pmem[{IBUS_A[8:2], 2'd3}]};

   // Reference model state and scoreboard queues.
   typedef struct { logic [31:0] a; logic [3:0] ba; logic we; logic [31:0] d; bit abort; } phase_t;
   typedef struct { bit aerr; bit berr; bit chk_do; logic [31:0] rd; } acc_t;

   logic [7:0] mmem [0:511];
   phase_t     phase_q[$];
   acc_t       acc_q[$];

   // Completion monitor: one check set each time the CPU sees the access end.
   acc_t e_mon;
   always @(negedge CLK) begin
      if (mon_on && CPU_REQ && !CPU_BUSY) begin
         if (acc_q.size() == 0) fail_now("unexpected_completion");
         else begin
            e_mon = acc_q.pop_front();
            chk("addr_err", 32'(ADDR_ERR), 32'(e_mon.aerr));
            chk("bus_err", 32'(BUS_ERR), 32'(e_mon.berr));
            chk("ibus_req_end", 32'(IBUS_REQ), 32'd0);
            if (e_mon.chk_do) chk("cpu_do", CPU_DO, e_mon.rd);
         end
      end
   end

   // Phase monitor: IBUS drive must match the expected phase on every cycle it is requested.
   phase_t ph;
   bit     started = 1'b0;
   always @(negedge CLK) begin
      if (mon_on) begin
         if (IBUS_REQ) begin
            if (phase_q.size() == 0) fail_now("spurious_ibus_req");
            else begin
               ph = phase_q[0];
               chk("ibus_a", IBUS_A, ph.a);
               chk("ibus_ba", 32'(IBUS_BA), 32'(ph.ba));
               chk("ibus_we", 32'(IBUS_WE), 32'(ph.we));
               chk("ibus_do", IBUS_DO, ph.d);
               started = 1'b1;
               if (CE_R && EN && !IBUS_BUSY) begin
                  void'(phase_q.pop_front());
                  started = 1'b0;
               end
            end
         end else if (phase_q.size() != 0 && phase_q[0].abort && started) begin
            void'(phase_q.pop_front());
            started = 1'b0;
         end
      end
   end

   // mode: 0 = steady enables, 1 = random CE_R/EN, 2 = EN low for three cycles after accept
   task automatic do_access(input logic [31:0] a, input logic [1:0] sz, input logic we,
                            input logic [31:0] di, input int w, input int mode);
      int n, nph, exp_ticks, ticks, lane;
      bit mis, in_reg, terr, done;
      logic [31:0] ak, rd;
      logic [3:0]  ba_all, one;
      phase_t p;
      acc_t   e;
      n      = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      mis    = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'd0);
      in_reg = (a >= LO) && (a <= HI);
      terr   = !mis && (w >= TMO);
      ba_all = '0;
      rd     = '0;
      one    = 4'b1000;
      for (int k = 0; k < n; k++) begin
         ak   = a + 32'(k);
         lane = int'(ak[1:0]);
         ba_all[3-lane] = 1'b1;
         if (!mis && !terr) begin
            if (we) mmem[ak[8:0]] = di[31-8*lane -: 8];
            else if (act_of(ak)) rd[31-8*lane -: 8] = mmem[ak[8:0]];
         end
         if (!mis && in_reg && (!terr || k == 0)) begin
            p.a = ak; p.ba = one >> ak[1:0]; p.we = we; p.d = di; p.abort = terr;
            phase_q.push_back(p);
         end
      end
      if (!mis && !in_reg) begin
         p.a = a; p.ba = ba_all; p.we = we; p.d = di; p.abort = terr;
         phase_q.push_back(p);
      end
      e.aerr = mis; e.berr = terr; e.chk_do = mis || terr || !we; e.rd = (mis || terr) ? 32'd0 : rd;
      acc_q.push_back(e);
      nph       = mis ? 0 : in_reg ? n : 1;
      exp_ticks = mis ? 1 : terr ? 1 + TMO : 1 + nph * (w + 1);

      wait_cfg = w; CPU_A = a; CPU_SZ = sz; CPU_WE = we; CPU_DI = di; CPU_REQ = 1'b1;
      ticks = 0;
      done  = 1'b0;
      for (int c = 0; c < 400 && !done; c++) begin
         @(posedge CLK);
         if (CE_R && EN) ticks++;
         #1;
         if (mode == 1) begin
            CE_R = ($urandom_range(0, 3) != 0);
            EN   = ($urandom_range(0, 5) != 0);
         end else if (mode == 2) EN = !(c >= 1 && c <= 3);
         @(negedge CLK);
         if (!CPU_BUSY) done = 1'b1;
      end
      if (!done) fail_now("access_never_completed");
      chk("latency", 32'(ticks), 32'(exp_ticks));
      $display("access a=%h sz=%0d we=%0d w=%0d mode=%0d ticks=%0d do=%h", a, sz, we, w, mode, ticks, CPU_DO);
      @(posedge CLK);
      #1 CPU_REQ = 1'b0; CE_R = 1'b1; EN = 1'b1;
      @(posedge CLK);
      #1;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ra;
      logic [1:0]  rs;
      int          rw, r;
      bit          found;
      for (int i = 0; i < 512; i++) mmem[i] = 8'(i * 7 + 3);

      #3;
      chk("rst_ibus_req", 32'(IBUS_REQ), 32'd0);
      chk("rst_ibus_we", 32'(IBUS_WE), 32'd0);
      chk("rst_ibus_ba", 32'(IBUS_BA), 32'd0);
      chk("rst_ibus_a", IBUS_A, 32'd0);
      chk("rst_ibus_do", IBUS_DO, 32'd0);
      chk("rst_cpu_do", CPU_DO, 32'd0);
      chk("rst_errs", {30'd0, ADDR_ERR, BUS_ERR}, 32'd0);
      repeat (4) @(posedge CLK);
      #1 RST_N = 1'b1;
      @(posedge CLK);
      #1;

      do_access(32'hFFFFFE12, 2'd1, 1'b1, 32'h00001234, 0, 0);
      do_access(32'hFFFFFE10, 2'd2, 1'b1, 32'hAABBCCDD, 0, 0);
      do_access(32'hFFFFFE10, 2'd2, 1'b0, 32'h0, 0, 0);
      do_access(32'hFFFFFF00, 2'd2, 1'b0, 32'h0, 0, 0);
      do_access(32'hFFFFFE20, 2'd1, 1'b0, 32'h0, 5, 0);
      do_access(32'hFFFFFE20, 2'd1, 1'b0, 32'h0, TMO - 1, 0);
      do_access(32'hFFFFFE30, 2'd2, 1'b0, 32'h0, TMO, 0);
      do_access(32'hFFFFFE11, 2'd1, 1'b0, 32'h0, 0, 0);
      do_access(32'hFFFFFE12, 2'd2, 1'b1, 32'h11223344, 0, 0);
      do_access(32'hFFFFFE75, 2'd0, 1'b0, 32'h0, 1, 0);
      do_access(32'hFFFFFE7C, 2'd2, 1'b0, 32'h0, 0, 0);
      do_access(32'hFFFFFE80, 2'd2, 1'b0, 32'h0, 0, 0);
      do_access(32'hFFFFFDFE, 2'd1, 1'b1, 32'h0000BEEF, 1, 0);
      do_access(32'hFFFFFDFE, 2'd1, 1'b0, 32'h0, 0, 0);
      do_access(32'hFFFFFE24, 2'd1, 1'b0, 32'h0, 2, 2);
      do_access(32'hFFFFFE14, 2'd3, 1'b0, 32'h0, 0, 0);

      for (int t = 0; t < 300; t++) begin
         r = $urandom_range(0, 9);
         if (r < 6) ra = LO + 32'($urandom_range(0, 127));
         else if (r < 8) ra = 32'hFFFFFF00 + 32'($urandom_range(0, 255));
         else ra = $urandom;
         rs = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 7) != 0) begin
            if (rs == 2'd1) ra[0] = 1'b0;
            if (rs[1]) ra[1:0] = 2'd0;
         end
         rw = ($urandom_range(0, 19) == 0) ? TMO + $urandom_range(0, 4) : $urandom_range(0, 3);
         do_access(ra, rs, 1'($urandom_range(0, 1)), $urandom, rw, 1);
      end

      chk("queues_drained", 32'(acc_q.size() + phase_q.size()), 32'd0);

      // Asynchronous reset in the middle of the second byte phase of a word read.
      mon_on   = 1'b0;
      wait_cfg = 3;
      CPU_A = 32'hFFFFFE12; CPU_SZ = 2'd1; CPU_WE = 1'b0; CPU_REQ = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 50 && !found; c++) begin
         @(negedge CLK);
         if (IBUS_REQ && IBUS_A == 32'hFFFFFE13) found = 1'b1;
      end
      chk("reached_phase2", 32'(found), 32'd1);
      #2 RST_N = 1'b0;
      #1;
      chk("midrst_ibus_req", 32'(IBUS_REQ), 32'd0);
      chk("midrst_ibus_a", IBUS_A, 32'd0);
      chk("midrst_ibus_ba", 32'(IBUS_BA), 32'd0);
      chk("midrst_ibus_do", IBUS_DO, 32'd0);
      chk("midrst_cpu_do", CPU_DO, 32'd0);
      @(posedge CLK);
      #1 CPU_REQ = 1'b0;
      RST_N = 1'b1;
      @(posedge CLK);
      #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
